// File: rtl/pool_mem_arbiter_2_pkg.sv
// pool_mem_arbiter_2_pkg: shared layer-2 state encoding and pooled-memory address width
package pool_mem_arbiter_2_pkg;
  localparam int POOL_ADDR_WIDTH = 10;
  typedef enum logic [2:0] {
    W_OWN   = 3'd0,
    W_DRAIN = 3'd1,
    FULL    = 3'd2,
    R_OWN   = 3'd3,
    R_DRAIN = 3'd4
  } state_t;
endpackage

// File: rtl/pool_port_mux_2.sv
// pool_port_mux_2: owner-select of address and strobes onto the pooled memory ports
module pool_port_mux_2 import pool_mem_arbiter_2_pkg::*; #(
  parameter int AW = POOL_ADDR_WIDTH
) (
  input  logic          i_sel_wr,
  input  logic          i_sel_rd,
  input  logic [AW-1:0] i_wr_addr_a,
  input  logic [AW-1:0] i_wr_addr_b,
  input  logic [3:0]    i_wr_strb,
  input  logic [AW-1:0] i_rd_addr_a,
  input  logic [AW-1:0] i_rd_addr_b,
  input  logic [3:0]    i_rd_strb,
  output logic [AW-1:0] o_addr_a,
  output logic [AW-1:0] o_addr_b,
  output logic [3:0]    o_strb
);
  // with no owner selected the memory sees address 0 and no strobes
  always_comb begin
    o_addr_a = i_sel_wr ? i_wr_addr_a : i_sel_rd ? i_rd_addr_a : '0;
    o_addr_b = i_sel_wr ? i_wr_addr_b : i_sel_rd ? i_rd_addr_b : '0;
    o_strb   = i_sel_wr ? i_wr_strb   : i_sel_rd ? i_rd_strb   : '0;
  end
endmodule

// File: rtl/pool_mem_arbiter_2.sv
// pool_mem_arbiter_2: frame-level ownership handshake of the layer-2 pooled-output memory
module pool_mem_arbiter_2 #(
  parameter int POOL_ADDR_WIDTH = pool_mem_arbiter_2_pkg::POOL_ADDR_WIDTH,
  parameter int DRAIN_CYCLES    = 2,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wr_done,
  input  logic [POOL_ADDR_WIDTH-1:0] wr_address_a,
  input  logic [POOL_ADDR_WIDTH-1:0] wr_address_b,
  input  logic                       wr_rden_a,
  input  logic                       wr_rden_b,
  input  logic                       wr_wren_a,
  input  logic                       wr_wren_b,
  input  logic                       rd_req,
  input  logic                       rd_done,
  input  logic [POOL_ADDR_WIDTH-1:0] rd_address_a,
  input  logic [POOL_ADDR_WIDTH-1:0] rd_address_b,
  input  logic                       rd_rden_a,
  input  logic                       rd_rden_b,
  input  logic                       rd_wren_a,
  input  logic                       rd_wren_b,
  output logic [POOL_ADDR_WIDTH-1:0] mem_address_a,
  output logic [POOL_ADDR_WIDTH-1:0] mem_address_b,
  output logic                       mem_rden_a,
  output logic                       mem_rden_b,
  output logic                       mem_wren_a,
  output logic                       mem_wren_b,
  output logic                       wr_grant,
  output logic                       rd_grant,
  output logic                       layer_start,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       access_err
);
  import pool_mem_arbiter_2_pkg::*;

  state_t                     r_state, w_next;
  logic [3:0]                 r_drain;
  logic                       r_in_rst, r_wr_grant, r_rd_grant, r_layer_start, r_err;
  logic [FRAME_CNT_WIDTH-1:0] r_frame_count;
  logic [3:0]                 w_wr_strb, w_rd_strb, w_mem_strb;
  logic                       w_drain_done, w_in_drain, w_take;

  assign w_wr_strb    = {wr_rden_a, wr_rden_b, wr_wren_a, wr_wren_b};
  assign w_rd_strb    = {rd_rden_a, rd_rden_b, rd_wren_a, rd_wren_b};
  assign w_in_drain   = r_state == W_DRAIN || r_state == R_DRAIN;
  assign w_drain_done = r_drain == 4'(DRAIN_CYCLES - 1);
  assign w_take       = r_state == FULL && rd_req;

  // next-state: done pulses and rd_req only matter in the state that owns them
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      W_OWN:   w_next = wr_done      ? W_DRAIN : W_OWN;
      W_DRAIN: w_next = w_drain_done ? FULL    : W_DRAIN;
      FULL:    w_next = rd_req       ? R_OWN   : FULL;
      R_OWN:   w_next = rd_done      ? R_DRAIN : R_OWN;
      R_DRAIN: w_next = w_drain_done ? W_OWN   : R_DRAIN;
      default: w_next = W_OWN;
    endcase
  end

  // state register
  always_ff @(posedge clock) r_state <= reset ? W_OWN : w_next;

  // drain counter runs only while retiring accesses and restarts on each drain
  always_ff @(posedge clock)
    r_drain <= (reset || w_drain_done || !w_in_drain) ? 4'd0 : r_drain + 4'd1;

  // registered grants, start pulse, frame counter and sticky error; all held at 0 in reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_rst      <= 1'b1;
      r_wr_grant    <= 1'b0;
      r_rd_grant    <= 1'b0;
      r_layer_start <= 1'b0;
      r_frame_count <= '0;
      r_err         <= 1'b0;
    end else begin
      r_in_rst      <= 1'b0;
      r_wr_grant    <= w_next == W_OWN;
      r_rd_grant    <= w_next == R_OWN;
      r_layer_start <= r_in_rst | (r_state == R_DRAIN && w_drain_done);
      r_frame_count <= r_frame_count + FRAME_CNT_WIDTH'(w_take);
      r_err         <= r_err | (|w_wr_strb & ~r_wr_grant) | (|w_rd_strb & ~r_rd_grant);
    end
  end

  pool_port_mux_2 #(.AW(POOL_ADDR_WIDTH)) u_mux (
    .i_sel_wr   (r_wr_grant),
    .i_sel_rd   (r_rd_grant),
    .i_wr_addr_a(wr_address_a),
    .i_wr_addr_b(wr_address_b),
    .i_wr_strb  (w_wr_strb),
    .i_rd_addr_a(rd_address_a),
    .i_rd_addr_b(rd_address_b),
    .i_rd_strb  (w_rd_strb),
    .o_addr_a   (mem_address_a),
    .o_addr_b   (mem_address_b),
    .o_strb     (w_mem_strb)
  );

  assign {mem_rden_a, mem_rden_b, mem_wren_a, mem_wren_b} = w_mem_strb;
  assign wr_grant    = r_wr_grant;
  assign rd_grant    = r_rd_grant;
  assign layer_start = r_layer_start;
  assign frame_count = r_frame_count;
  assign access_err  = r_err;
endmodule

// File: tb/tb_pool_mem_arbiter_2.sv
// tb_pool_mem_arbiter_2: scenario and randomized checks against a frame-ownership model
module tb_pool_mem_arbiter_2;
  localparam int D = 2;
  logic clock = 0, reset = 1, wr_done = 0, rd_req = 0, rd_done = 0;
  logic [9:0] wr_address_a = 0, wr_address_b = 0, rd_address_a = 0, rd_address_b = 0;
  logic wr_rden_a = 0, wr_rden_b = 0, wr_wren_a = 0, wr_wren_b = 0;
  logic rd_rden_a = 0, rd_rden_b = 0, rd_wren_a = 0, rd_wren_b = 0;
  logic [9:0] mem_address_a, mem_address_b;
  logic mem_rden_a, mem_rden_b, mem_wren_a, mem_wren_b;
  logic wr_grant, rd_grant, layer_start, access_err;
  logic [7:0] frame_count;
  int errors = 0, checks = 0, cyc = 0;
  int m_owner = 1, m_drain = 0, m_fc = 0;
  bit m_live = 0, m_ready = 0, m_back_wr = 0, m_err = 0, m_start = 0, m_was_rst = 0;

  pool_mem_arbiter_2 dut (
    .clock(clock), .reset(reset), .wr_done(wr_done),
    .wr_address_a(wr_address_a), .wr_address_b(wr_address_b),
    .wr_rden_a(wr_rden_a), .wr_rden_b(wr_rden_b), .wr_wren_a(wr_wren_a), .wr_wren_b(wr_wren_b),
    .rd_req(rd_req), .rd_done(rd_done),
    .rd_address_a(rd_address_a), .rd_address_b(rd_address_b),
    .rd_rden_a(rd_rden_a), .rd_rden_b(rd_rden_b), .rd_wren_a(rd_wren_a), .rd_wren_b(rd_wren_b),
    .mem_address_a(mem_address_a), .mem_address_b(mem_address_b),
    .mem_rden_a(mem_rden_a), .mem_rden_b(mem_rden_b), .mem_wren_a(mem_wren_a), .mem_wren_b(mem_wren_b),
    .wr_grant(wr_grant), .rd_grant(rd_grant), .layer_start(layer_start),
    .frame_count(frame_count), .access_err(access_err)
  );

  always #5 clock = ~clock;

  // owner: 0 nobody, 1 writer, 2 reader; a drain counts down and then hands the memory on
  task automatic model_step();
    bit wg, rg;
    if (reset) begin
      m_live = 0; m_owner = 1; m_ready = 0; m_drain = 0; m_back_wr = 0;
      m_fc = 0; m_err = 0; m_start = 0; m_was_rst = 1;
    end else begin
      wg = m_live && m_owner == 1;
      rg = m_live && m_owner == 2;
      if (((rd_rden_a | rd_rden_b | rd_wren_a | rd_wren_b) && !rg) ||
          ((wr_rden_a | wr_rden_b | wr_wren_a | wr_wren_b) && !wg)) m_err = 1;
      m_start = m_was_rst; m_was_rst = 0; m_live = 1;
      if (m_owner == 1 && wr_done) begin
        m_owner = 0; m_drain = D; m_back_wr = 0;
      end else if (m_owner == 0 && m_drain > 0) begin
        m_drain--;
        if (m_drain == 0) begin
          if (m_back_wr) begin m_owner = 1; m_start = 1; end
          else m_ready = 1;
        end
      end else if (m_ready && rd_req) begin
        m_ready = 0; m_owner = 2; m_fc = (m_fc + 1) % 256;
      end else if (m_owner == 2 && rd_done) begin
        m_owner = 0; m_drain = D; m_back_wr = 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc = reset ? 0 : cyc + 1;
    model_step();
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear_inputs();
    {wr_done, rd_req, rd_done} = 0;
    {wr_rden_a, wr_rden_b, wr_wren_a, wr_wren_b, rd_rden_a, rd_rden_b, rd_wren_a, rd_wren_b} = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    repeat (2) tick();
    reset = 0;
  endtask

  task automatic frame(input bit finish);
    int n;
    wr_done = 1; tick(); wr_done = 0;
    rd_req = 1; n = 0;
    while (!rd_grant && n < 20) begin tick(); n++; end
    rd_req = 0; checks++;
    if (!rd_grant) begin errors++; $display("FAIL frame_grant_timeout rd_grant=%0b required=1", rd_grant); end
    if (finish) begin
      rd_done = 1; tick(); rd_done = 0; n = 0;
      while (!wr_grant && n < 20) begin tick(); n++; end
      checks++;
      if (!wr_grant) begin errors++; $display("FAIL frame_return_timeout wr_grant=%0b required=1", wr_grant); end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({wr_grant, rd_grant, layer_start, access_err, frame_count, mem_address_a, mem_rden_a} !== 0) begin
      errors++;
      $display("FAIL reset_outputs got=%0b,%0b,%0b,%0b,%0h,%0h required all 0", wr_grant, rd_grant, layer_start, access_err, frame_count, mem_address_a);
    end
  endtask

  task automatic test_basic_frame();
    run_to(1); checks++;
    if ({layer_start, wr_grant} !== 2'b11) begin errors++; $display("FAIL basic_start_c1 start,wgrant=%b required=11", {layer_start, wr_grant}); end
    run_to(2); checks++;
    if (layer_start !== 0) begin errors++; $display("FAIL basic_start_c2 got=%b required=0", layer_start); end
    run_to(20); wr_done = 1; run_to(21); wr_done = 0; checks++;
    if ({wr_grant, rd_grant} !== 2'b00) begin errors++; $display("FAIL basic_wdrain_c21 grants=%b required=00", {wr_grant, rd_grant}); end
    run_to(30); rd_req = 1; run_to(31); rd_req = 0; checks++;
    if ({rd_grant, frame_count} !== {1'b1, 8'd1}) begin errors++; $display("FAIL basic_rgrant_c31 rg=%b fc=%0d required rg=1 fc=1", rd_grant, frame_count); end
    run_to(50); rd_done = 1; run_to(51); rd_done = 0; checks++;
    if (rd_grant !== 0) begin errors++; $display("FAIL basic_rdrain_c51 rg=%b required=0", rd_grant); end
    run_to(52); checks++;
    if ({wr_grant, layer_start} !== 2'b00) begin errors++; $display("FAIL basic_rdrain_c52 wg,start=%b required=00", {wr_grant, layer_start}); end
    run_to(53); checks++;
    if ({wr_grant, layer_start} !== 2'b11) begin errors++; $display("FAIL basic_return_c53 wg,start=%b required=11", {wr_grant, layer_start}); end
  endtask

  task automatic test_mux();
    int n;
    logic [9:0] ab;
    wr_address_a = 10'h155; wr_wren_a = 1; rd_address_a = 10'h2AA; wr_done = 1;
    #1; checks++;
    if ({mem_address_a, mem_wren_a} !== {10'h155, 1'b1}) begin errors++; $display("FAIL mux_wr addr=%0h wren=%b required 155,1", mem_address_a, mem_wren_a); end
    tick(); wr_done = 0; wr_wren_a = 0;
    #1; checks++;
    if ({mem_address_a, mem_wren_a, access_err} !== 0) begin errors++; $display("FAIL mux_wdrain addr=%0h wren=%b err=%b required 0", mem_address_a, mem_wren_a, access_err); end
    rd_req = 1; n = 0;
    while (!rd_grant && n < 20) begin tick(); n++; end
    rd_req = 0;
    ab = 10'($urandom);
    rd_address_b = ab; rd_rden_b = 1; rd_done = 1;
    #1; checks++;
    if ({rd_grant, mem_address_b, mem_rden_b, mem_address_a} !== {1'b1, ab, 1'b1, 10'h2AA}) begin
      errors++; $display("FAIL mux_rd rg=%b addr_b=%0h rden_b=%b addr_a=%0h required 1,%0h,1,2aa", rd_grant, mem_address_b, mem_rden_b, mem_address_a, ab);
    end
    tick(); rd_rden_b = 0; rd_done = 0;
    #1; checks++;
    if ({rd_grant, mem_address_b, mem_rden_b, access_err} !== 0) begin errors++; $display("FAIL mux_rdrain rg=%b addr_b=%0h err=%b required 0", rd_grant, mem_address_b, access_err); end
    n = 0;
    while (!wr_grant && n < 20) begin tick(); n++; end
  endtask

  task automatic test_illegal();
    do_reset();
    run_to(3); rd_rden_b = 1;
    #1; checks++;
    if ({mem_rden_b, access_err} !== 2'b00) begin errors++; $display("FAIL illegal_block rden_b=%b err=%b required 00", mem_rden_b, access_err); end
    tick(); rd_rden_b = 0; checks++;
    if (access_err !== 1) begin errors++; $display("FAIL illegal_flag err=%b required=1", access_err); end
    repeat (6) tick();
    checks++;
    if (access_err !== 1) begin errors++; $display("FAIL illegal_sticky err=%b required=1", access_err); end
    do_reset(); checks++;
    if (access_err !== 0) begin errors++; $display("FAIL illegal_cleared err=%b required=0", access_err); end
  endtask

  task automatic test_early_request();
    do_reset();
    run_to(5); rd_req = 1;
    run_to(10); wr_done = 1; run_to(11); wr_done = 0;
    run_to(13); checks++;
    if (rd_grant !== 0) begin errors++; $display("FAIL early_c13 rg=%b required=0", rd_grant); end
    run_to(14); checks++;
    if ({rd_grant, frame_count} !== {1'b1, 8'd1}) begin errors++; $display("FAIL early_c14 rg=%b fc=%0d required 1,1", rd_grant, frame_count); end
    rd_req = 0;
  endtask

  task automatic test_reset_in_rown();
    do_reset(); tick();
    frame(1); frame(1); frame(0);
    checks++;
    if ({rd_grant, frame_count} !== {1'b1, 8'd3}) begin errors++; $display("FAIL rrst_setup rg=%b fc=%0d required 1,3", rd_grant, frame_count); end
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      tick(); checks++;
      if ({wr_grant, rd_grant, layer_start, access_err, frame_count, mem_address_a, mem_address_b} !== 0) begin
        errors++; $display("FAIL rrst_held cycle=%0d wg=%b rg=%b start=%b fc=%0d required all 0", i, wr_grant, rd_grant, layer_start, frame_count);
      end
    end
    reset = 0; tick(); checks++;
    if ({wr_grant, layer_start, frame_count} !== {2'b11, 8'd0}) begin errors++; $display("FAIL rrst_release wg=%b start=%b fc=%0d required 1,1,0", wr_grant, layer_start, frame_count); end
    tick(); checks++;
    if ({wr_grant, layer_start} !== 2'b10) begin errors++; $display("FAIL rrst_single_pulse wg=%b start=%b required 1,0", wr_grant, layer_start); end
  endtask

  task automatic test_wrap();
    do_reset(); tick();
    for (int i = 0; i < 255; i++) frame(1);
    checks++;
    if (frame_count !== 8'd255) begin errors++; $display("FAIL wrap_255 fc=%0d required=255", frame_count); end
    frame(0); checks++;
    if ({frame_count, access_err} !== 9'd0) begin errors++; $display("FAIL wrap_256 fc=%0d err=%b required 0,0", frame_count, access_err); end
  endtask

  task automatic test_random();
    logic [35:0] got, exp;
    bit wg, rg;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      wg = m_live && m_owner == 1;
      rg = m_live && m_owner == 2;
      reset = $urandom_range(0, 399) == 0;
      {wr_rden_a, wr_rden_b, wr_wren_a, wr_wren_b} = (wg || $urandom_range(0, 499) == 0) ? 4'($urandom) : 4'd0;
      {rd_rden_a, rd_rden_b, rd_wren_a, rd_wren_b} = (rg || $urandom_range(0, 499) == 0) ? 4'($urandom) : 4'd0;
      wr_done = $urandom_range(0, 5) == 0;
      rd_done = $urandom_range(0, 5) == 0;
      rd_req = $urandom_range(0, 2) == 0;
      {wr_address_a, wr_address_b, rd_address_a, rd_address_b} = {10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom)};
      #1;
      got = {wr_grant, rd_grant, layer_start, access_err, frame_count, mem_address_a, mem_address_b,
             mem_rden_a, mem_rden_b, mem_wren_a, mem_wren_b};
      exp = {wg, rg, m_start, m_err, 8'(m_fc),
             wg ? wr_address_a : rg ? rd_address_a : 10'd0,
             wg ? wr_address_b : rg ? rd_address_b : 10'd0,
             wg ? {wr_rden_a, wr_rden_b, wr_wren_a, wr_wren_b} : rg ? {rd_rden_a, rd_rden_b, rd_wren_a, rd_wren_b} : 4'd0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL random step=%0d got=%h required=%h", i, got, exp); end
      tick();
    end
    reset = 0;
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_mux();
    test_illegal();
    test_early_request();
    test_reset_in_rown();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
